// File: rtl/eth_pkg.sv
// Shared Ethernet TX constants and the frame-engine state type.
package eth_pkg;
  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC_POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT     = 32'hFFFFFFFF;
  localparam int unsigned MTU          = 1536;
  localparam int unsigned MIN_FRAME    = 60;
  localparam int unsigned IFG_BYTES    = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_IFG
  } tx_state_t;
endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational one-octet step of the reflected IEEE CRC32.
module eth_crc32_byte (
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);
  import eth_pkg::*;

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h000000, data_in};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end
endmodule

// File: rtl/eth_tx_frame_engine.sv
// Reads a payload from the TX BRAM and streams a complete Ethernet frame
// (preamble, SFD, payload, zero pad, FCS) followed by the inter-frame gap.
module eth_tx_frame_engine #(
  parameter int unsigned MTU       = eth_pkg::MTU,
  parameter int unsigned ADDR_W    = 11,
  parameter int unsigned MIN_FRAME = eth_pkg::MIN_FRAME,
  parameter int unsigned IFG_BYTES = eth_pkg::IFG_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       tx_len,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [7:0]        buf_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_sof,
  output logic              tx_eof
);
  import eth_pkg::*;

  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  tx_state_t       state;
  logic [15:0]     len_q;
  logic [ADDR_W:0] cnt;
  logic [ADDR_W:0] rd_idx;
  logic [5:0]      pad_cnt;
  logic [5:0]      ifg_cnt;
  logic [31:0]     crc;
  logic [31:0]     crc_nx;
  logic [7:0]      fcs_next;

  logic [7:0]      fifo_mem [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      fifo_cnt;
  logic [1:0]      occ;
  logic            rd_pending;

  logic            advance;
  logic            last_data;
  logic            pop;
  logic            reads_left;
  logic            issue;

  eth_crc32_byte u_crc (
    .crc_in  (crc),
    .data_in (tx_data),
    .crc_out (crc_nx)
  );

  assign advance    = tx_valid & tx_ready;
  assign last_data  = (16'(cnt) == (len_q - 16'd1));
  assign pop        = advance && ((state == S_SFD) || ((state == S_DATA) && !last_data));
  assign reads_left = (16'(rd_idx) < len_q) && (state inside {S_PRE, S_SFD, S_DATA});
  assign occ        = fifo_cnt + 2'(rd_pending);
  // Keep at most two bytes in flight or buffered so a pop every cycle never starves.
  assign issue      = reads_left && ((occ < 2'd2) || (pop && (occ == 2'd2)));

  always_comb begin
    fcs_next = ~crc[31:24];
    case (cnt[1:0])
      2'd0:    fcs_next = ~crc[15:8];
      2'd1:    fcs_next = ~crc[23:16];
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_addr   <= '0;
      rd_idx     <= '0;
      rd_pending <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_cnt   <= '0;
    end else if (state == S_IDLE) begin
      buf_addr   <= '0;
      rd_idx     <= '0;
      rd_pending <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_cnt   <= '0;
    end else begin
      rd_pending <= issue;
      if (issue) begin
        rd_idx <= rd_idx + CNT_ONE;
        // Address stops at len-1 so nothing past the payload is ever read.
        if ((16'(rd_idx) + 16'd1) < len_q) buf_addr <= buf_addr + ADDR_ONE;
      end
      if (rd_pending) wr_ptr <= ~wr_ptr;
      if (pop)        rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(rd_pending) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rd_pending) fifo_mem[wr_ptr] <= buf_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_len  <= 1'b0;
      tx_valid <= 1'b0;
      tx_sof   <= 1'b0;
      tx_eof   <= 1'b0;
      tx_data  <= '0;
      len_q    <= '0;
      cnt      <= '0;
      pad_cnt  <= '0;
      ifg_cnt  <= '0;
      crc      <= CRC_INIT;
    end else begin
      done    <= 1'b0;
      err_len <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !done) begin
            if ((tx_len == '0) || (tx_len > 16'(MTU))) begin
              err_len <= 1'b1;
            end else begin
              len_q    <= tx_len;
              cnt      <= '0;
              crc      <= CRC_INIT;
              busy     <= 1'b1;
              tx_valid <= 1'b1;
              tx_sof   <= 1'b1;
              tx_data  <= ETH_PREAMBLE;
              state    <= S_PRE;
            end
          end
        end
        S_PRE: begin
          if (advance) begin
            tx_sof <= 1'b0;
            if (cnt[2:0] == 3'd6) begin
              tx_data <= ETH_SFD;
              state   <= S_SFD;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
        end
        S_SFD: begin
          if (advance) begin
            cnt     <= '0;
            tx_data <= fifo_mem[rd_ptr];
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (advance) begin
            crc <= crc_nx;
            if (last_data) begin
              cnt <= '0;
              if (len_q < 16'(MIN_FRAME)) begin
                pad_cnt <= 6'(16'(MIN_FRAME) - len_q - 16'd1);
                tx_data <= '0;
                state   <= S_PAD;
              end else begin
                tx_data <= ~crc_nx[7:0];
                state   <= S_FCS;
              end
            end else begin
              cnt     <= cnt + CNT_ONE;
              tx_data <= fifo_mem[rd_ptr];
            end
          end
        end
        S_PAD: begin
          if (advance) begin
            crc <= crc_nx;
            if (pad_cnt == '0) begin
              tx_data <= ~crc_nx[7:0];
              state   <= S_FCS;
            end else begin
              pad_cnt <= pad_cnt - 6'd1;
            end
          end
        end
        S_FCS: begin
          if (advance) begin
            if (cnt[1:0] == 2'd3) begin
              tx_valid <= 1'b0;
              tx_eof   <= 1'b0;
              ifg_cnt  <= '0;
              state    <= S_IFG;
            end else begin
              cnt     <= cnt + CNT_ONE;
              tx_data <= fcs_next;
              tx_eof  <= (cnt[1:0] == 2'd2);
            end
          end
        end
        S_IFG: begin
          if (tx_ready) begin
            if (ifg_cnt == 6'(IFG_BYTES - 1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_IDLE;
            end else begin
              ifg_cnt <= ifg_cnt + 6'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_tx_frame_engine.sv
// Self-checking bench for eth_tx_frame_engine: table of frame vectors against a
// queue-based golden frame model, plus reset and back-to-back sequences.
module tb_eth_tx_frame_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] tx_len = '0;
  logic        busy, done, err_len;
  logic [10:0] buf_addr;
  logic [7:0]  buf_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_sof, tx_eof;

  always #5 clk = ~clk;

  eth_tx_frame_engine #(
    .MTU       (1536),
    .ADDR_W    (11),
    .MIN_FRAME (60),
    .IFG_BYTES (12)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tx_len    (tx_len),
    .busy      (busy),
    .done      (done),
    .err_len   (err_len),
    .buf_addr  (buf_addr),
    .buf_rdata (buf_rdata),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_sof    (tx_sof),
    .tx_eof    (tx_eof)
  );

  logic [31:0] c_in;
  logic [7:0]  c_byte;
  logic [31:0] c_out;
  eth_crc32_byte u_crc_unit (.crc_in(c_in), .data_in(c_byte), .crc_out(c_out));

  logic [7:0] mem [2048];
  always @(posedge clk) buf_rdata <= mem[buf_addr];

  typedef struct {
    int len;
    int pct;
    bit inc;
    bit mid;
    bit bad;
    int exp_total;
  } vec_t;
  vec_t vecs [11];

  int n_vec = 0;
  int n_mis = 0;
  int cyc = 0;
  int ready_pct = 100;

  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];
  int sof_idx [$];
  int eof_idx [$];
  int first_valid_cyc, sof_cyc, eof_cyc, done_cyc, ifg_slots, max_addr, stall_bad, err_cnt;
  bit in_gap = 1'b0;
  bit done_busy;
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_sof = 1'b0, prev_eof = 1'b0;
  logic [7:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      in_gap     = 1'b0;
    end else begin
      if (prev_valid && !prev_ready &&
          (!tx_valid || tx_data !== prev_data || tx_sof !== prev_sof || tx_eof !== prev_eof))
        stall_bad++;
      if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (tx_valid && tx_ready) begin
        got_q.push_back(tx_data);
        if (tx_sof) begin sof_idx.push_back(got_q.size() - 1); sof_cyc = cyc; end
        if (tx_eof) begin eof_idx.push_back(got_q.size() - 1); eof_cyc = cyc; in_gap = 1'b1; ifg_slots = 0; end
      end else if (done) begin
        in_gap    = 1'b0;
        done_cyc  = cyc;
        done_busy = busy;
      end else if (in_gap && tx_ready) begin
        ifg_slots++;
      end
      if (err_len) err_cnt++;
      if (busy && int'(buf_addr) > max_addr) max_addr = int'(buf_addr);
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
      prev_sof   = tx_sof;
      prev_eof   = tx_eof;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Bit-serial LSB-first CRC32 straight from the polynomial definition.
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic build_exp(input int len);
    logic [31:0] crc;
    logic [31:0] fcs;
    int body;
    exp_q.delete();
    repeat (7) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    crc  = 32'hFFFFFFFF;
    body = (len < 60) ? 60 : len;
    for (int i = 0; i < body; i++) begin
      logic [7:0] b;
      b = (i < len) ? mem[i] : 8'h00;
      exp_q.push_back(b);
      crc = crc_model(crc, b);
    end
    fcs = ~crc;
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(fcs >> (8 * k)));
  endtask

  task automatic clear_mon();
    got_q.delete();
    sof_idx.delete();
    eof_idx.delete();
    first_valid_cyc = -1;
    sof_cyc = -1;
    eof_cyc = -1;
    done_cyc = -1;
    ifg_slots = 0;
    max_addr = 0;
    stall_bad = 0;
    err_cnt = 0;
  endtask

  task automatic run_frame(input vec_t v);
    int start_cyc;
    int k;
    int bad;
    bit fired;
    for (int i = 0; i < 2048; i++) mem[i] = v.inc ? 8'(i) : 8'($urandom);
    ready_pct = v.pct;
    build_exp(v.len);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    tx_len = 16'(v.len);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_rise", busy, 1);
    k = 0;
    fired = 1'b0;
    while (done_cyc < 0 && k < 20000) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (v.mid && !fired && got_q.size() >= 28) begin
        start  = 1'b1;
        tx_len = 16'd5;
        fired  = 1'b1;
      end
      k++;
    end
    start = 1'b0;
    check("done_timeout", (done_cyc >= 0) ? 1 : 0, 1);
    check("octet_count", got_q.size(), v.exp_total);
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
    check("octet_data", bad, 0);
    check("sof_pos", (sof_idx.size() == 1) ? sof_idx[0] : -1, 0);
    check("eof_pos", (eof_idx.size() == 1) ? eof_idx[0] : -1, exp_q.size() - 1);
    check("sof_latency_le2", (first_valid_cyc - start_cyc >= 1 && first_valid_cyc - start_cyc <= 2) ? 1 : 0, 1);
    check("ifg_slots", ifg_slots, 12);
    check("done_busy_low", done_busy, 0);
    check("max_addr", max_addr, v.len - 1);
    check("stall_hold", stall_bad, 0);
    check("no_err", err_cnt, 0);
    if (v.pct == 100) begin
      check("no_bubbles", eof_cyc - sof_cyc, v.exp_total - 1);
      check("done_gap", done_cyc - eof_cyc, 13);
    end
    if (v.mid) begin
      repeat (5) @(negedge clk);
      check("mid_start_ignored", busy, 0);
      check("mid_start_octets", got_q.size(), v.exp_total);
    end
  endtask

  task automatic run_err(input int len);
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    tx_len = 16'(len);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("err_pulse", err_len, 1);
    check("err_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("err_count", err_cnt, 1);
    check("err_no_octets", got_q.size(), 0);
    check("err_busy_after", busy, 0);
  endtask

  initial begin
    vec_t v60;
    string s;
    logic [31:0] c;
    int k;

    vecs = '{
      '{64,   100, 1'b1, 1'b0, 1'b0, 76},
      '{14,   100, 1'b0, 1'b0, 1'b0, 72},
      '{1500, 50,  1'b0, 1'b0, 1'b0, 1512},
      '{0,    100, 1'b0, 1'b0, 1'b1, 0},
      '{1537, 100, 1'b0, 1'b0, 1'b1, 0},
      '{59,   100, 1'b0, 1'b0, 1'b0, 72},
      '{60,   70,  1'b0, 1'b0, 1'b0, 72},
      '{61,   100, 1'b0, 1'b0, 1'b0, 73},
      '{1,    40,  1'b0, 1'b0, 1'b0, 72},
      '{1536, 100, 1'b0, 1'b0, 1'b0, 1548},
      '{200,  100, 1'b0, 1'b1, 1'b0, 212}
    };

    s = "123456789";
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      c_in = c;
      c_byte = s[i];
      #1;
      check("crc_step", c_out, crc_model(c, s[i]));
      c = c_out;
    end
    check("crc_check_value", ~c, 32'hCBF43926);

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_len, 0);
    check("rst_valid", tx_valid, 0);
    check("rst_sof_eof", {tx_sof, tx_eof}, 0);
    check("rst_addr", buf_addr, 0);
    check("rst_data", tx_data, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].bad) run_err(vecs[i].len);
      else             run_frame(vecs[i]);
    end

    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    ready_pct = 100;
    clear_mon();
    @(posedge clk); #1;
    start = 1'b1;
    tx_len = 16'd100;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (got_q.size() < 28 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_data20", (got_q.size() >= 28) ? 1 : 0, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", tx_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_addr", buf_addr, 0);
    check("midrst_sof_eof", {tx_sof, tx_eof}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("midrst_no_eof", eof_idx.size(), 0);

    v60 = '{60, 100, 1'b0, 1'b0, 1'b0, 72};
    run_frame(v60);
    run_frame(v60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
